// File: rtl/pcm_pkg.sv
// Shared constants and types for the PCM playback path.
// Field offsets describe the packed stereo FIFO word.
package pcm_pkg;

    localparam int SAMPLE_W = 16;
    localparam int CNT_W    = 10;

    localparam int L_MSB = 31;
    localparam int L_LSB = 16;
    localparam int R_MSB = 15;
    localparam int R_LSB = 0;

    localparam int MIN_DIV = 2;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        LATCH
    } state_t;

endpackage

// File: rtl/pcm_rate_div.sv
// Sample-period divider: counts down while enabled, ticks at zero.
// The reload value is clamped so a period is never shorter than a fetch.
module pcm_rate_div #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic [DIV_W-1:0] rate_div,
    output logic             tick
);
    import pcm_pkg::*;

    logic [DIV_W-1:0] q_div;
    logic [DIV_W-1:0] reload;

    assign reload = (rate_div < DIV_W'(MIN_DIV)) ? DIV_W'(MIN_DIV) : rate_div;
    assign tick   = enable && (q_div == '0);

    // rate_div is only sampled on reload, so changes land at the next period
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_div <= '0;
        end else if (!enable || tick) begin
            q_div <= reload;
        end else begin
            q_div <= q_div - 1'b1;
        end
    end

endmodule

// File: rtl/pcm_player.sv
// PCM FIFO consumer: pops one stereo word per sample period and
// presents it to the DAC path, flagging underrun and low-water.
module pcm_player #(
    parameter int SAMPLE_W      = pcm_pkg::SAMPLE_W,
    parameter int DIV_W         = 16,
    parameter int CNT_W         = pcm_pkg::CNT_W,
    parameter int UNDERRUN_ZERO = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      rate_div,
    input  logic [2*SAMPLE_W-1:0] fifo_rddata,
    input  logic                  fifo_empty,
    input  logic [CNT_W-1:0]      fifo_count,
    output logic                  fifo_rd_en,
    input  logic [CNT_W-1:0]      irq_level,
    input  logic                  underrun_clr,
    output logic [SAMPLE_W-1:0]   sample_l,
    output logic [SAMPLE_W-1:0]   sample_r,
    output logic                  sample_strobe,
    output logic                  underrun,
    output logic                  irq
);
    import pcm_pkg::*;

    state_t     state;
    state_t     state_nx;
    logic       tick;
    logic       set_ur;
    logic [1:0] ur_pipe;

    pcm_rate_div #(
        .DIV_W(DIV_W)
    ) u_div (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .rate_div(rate_div),
        .tick    (tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (tick && !fifo_empty) state_nx = POP;
            POP:     state_nx = LATCH;
            LATCH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign set_ur = (state == IDLE) && tick && fifo_empty;

    // Underrun ticks ride a two-stage delay so the strobe keeps the
    // same T+3 cadence as a real fetch.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fifo_rd_en    <= 1'b0;
            ur_pipe       <= '0;
            sample_strobe <= 1'b0;
            sample_l      <= '0;
            sample_r      <= '0;
            underrun      <= 1'b0;
            irq           <= 1'b0;
        end else begin
            fifo_rd_en    <= (state_nx == POP);
            ur_pipe       <= {ur_pipe[0], set_ur};
            sample_strobe <= (state == LATCH) || ur_pipe[1];
            if (state == LATCH) begin
                sample_l <= fifo_rddata[L_MSB:L_LSB];
                sample_r <= fifo_rddata[R_MSB:R_LSB];
            end else if (ur_pipe[1] && (UNDERRUN_ZERO != 0)) begin
                sample_l <= '0;
                sample_r <= '0;
            end
            if (set_ur) begin
                underrun <= 1'b1;
            end else if (underrun_clr) begin
                underrun <= 1'b0;
            end
            irq <= enable && (fifo_count < irq_level);
        end
    end

endmodule

// File: tb/tb_pcm_player.sv
// Bench for pcm_player: FIFO model, event-level predictor, vector table,
// hand sequences for corner cases and a randomized soak.
module tb_pcm_player;

    localparam int DIV_W = 16;
    localparam int CNT_W = 10;

    logic             clk = 1'b0;
    logic             reset;
    logic             enable;
    logic [DIV_W-1:0] rate_div;
    logic [31:0]      fifo_rddata;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] irq_level;
    logic             underrun_clr;

    logic        rd_h, st_h, ur_h, irq_h;
    logic        rd_z, st_z, ur_z, irq_z;
    logic [15:0] l_h, r_h, l_z, r_z;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    pcm_player #(.UNDERRUN_ZERO(0)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rate_div(rate_div),
        .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .fifo_rd_en(rd_h), .irq_level(irq_level),
        .underrun_clr(underrun_clr), .sample_l(l_h), .sample_r(r_h),
        .sample_strobe(st_h), .underrun(ur_h), .irq(irq_h)
    );

    pcm_player #(.UNDERRUN_ZERO(1)) dut_z (
        .clk(clk), .reset(reset), .enable(enable), .rate_div(rate_div),
        .fifo_rddata(fifo_rddata), .fifo_empty(fifo_empty),
        .fifo_count(fifo_count), .fifo_rd_en(rd_z), .irq_level(irq_level),
        .underrun_clr(underrun_clr), .sample_l(l_z), .sample_r(r_z),
        .sample_strobe(st_z), .underrun(ur_z), .irq(irq_z)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // FIFO contents; pend carries pushes (bit 32 set = flush request)
    logic [31:0] fq[$];
    logic [32:0] pend[$];

    // Predictor state: expectations per cycle slot
    int          cyc = 0;
    int          nxt = -1;
    bit          rst_seen = 1'b1;
    logic [DIV_W-1:0] rd_prev = '0;
    logic        e_rd[16];
    logic        e_st[16];
    logic        e_sv[16];
    logic        e_ur[16];
    logic [31:0] e_w[16];
    logic        und_exp;
    logic        irq_exp;

    function automatic int per(input logic [DIV_W-1:0] r);
        return (r < 2) ? 3 : int'(r) + 1;
    endfunction

    always @(posedge clk) begin
        bit tick;
        bit emp;
        int s;
        tick = 1'b0;
        emp  = (fq.size() == 0);
        if (reset) begin
            nxt      = -1;
            rst_seen = 1'b1;
            und_exp  = 1'b0;
            irq_exp  = 1'b0;
            for (int i = 0; i < 16; i++) begin
                e_rd[i] = 1'b0;
                e_st[i] = 1'b0;
                e_sv[i] = 1'b0;
                e_ur[i] = 1'b0;
                e_w[i]  = '0;
            end
        end else begin
            if (!enable) begin
                nxt = -1;
            end else begin
                if (nxt < 0) nxt = rst_seen ? cyc : cyc + per(rd_prev) - 1;
                if (cyc == nxt) begin
                    tick = 1'b1;
                    nxt  = cyc + per(rate_div);
                end
            end
            rst_seen = 1'b0;
            s = (cyc + 4) % 16;
            e_rd[s] = 1'b0;
            e_st[s] = 1'b0;
            e_sv[s] = 1'b0;
            if (tick) begin
                e_st[(cyc + 3) % 16] = 1'b1;
                e_sv[(cyc + 3) % 16] = 1'b1;
                e_ur[(cyc + 3) % 16] = emp;
                if (!emp) begin
                    e_rd[(cyc + 1) % 16] = 1'b1;
                    e_w[(cyc + 3) % 16]  = fq[0];
                end
            end
            if (tick && emp) und_exp = 1'b1;
            else if (underrun_clr) und_exp = 1'b0;
            irq_exp = enable && (fifo_count < irq_level);
        end
        rd_prev = rate_div;
        if (rd_h) begin
            chk("pop_nonempty", 32'(fq.size() != 0), 32'd1);
            if (fq.size() != 0) fifo_rddata <= fq.pop_front();
        end
        while (pend.size() > 0) begin
            logic [32:0] p;
            p = pend.pop_front();
            if (p[32]) fq.delete();
            else fq.push_back(p[31:0]);
        end
        fifo_count <= CNT_W'(fq.size());
        fifo_empty <= (fq.size() == 0);
        cyc = cyc + 1;
    end

    // Per-cycle comparison against the predictor
    always @(posedge clk) begin
        int k;
        logic [15:0] cl, cr, czl, czr;
        #1;
        if (reset) begin
            cl = '0; cr = '0; czl = '0; czr = '0;
            chk("rst_outs", {l_h, r_h}, 32'd0);
            chk("rst_outs_z", {l_z, r_z}, 32'd0);
            chk("rst_flags", {28'd0, rd_h, st_h, ur_h, irq_h}, 32'd0);
            chk("rst_flags_z", {28'd0, rd_z, st_z, ur_z, irq_z}, 32'd0);
        end else begin
            k = cyc % 16;
            if (e_sv[k]) begin
                if (!e_ur[k]) begin
                    cl  = e_w[k][31:16];
                    cr  = e_w[k][15:0];
                    czl = e_w[k][31:16];
                    czr = e_w[k][15:0];
                end else begin
                    czl = '0;
                    czr = '0;
                end
            end
            chk("rd_en", 32'(rd_h), 32'(e_rd[k]));
            chk("rd_en_z", 32'(rd_z), 32'(e_rd[k]));
            chk("strobe", 32'(st_h), 32'(e_st[k]));
            chk("strobe_z", 32'(st_z), 32'(e_st[k]));
            chk("samples", {l_h, r_h}, {cl, cr});
            chk("samples_z", {l_z, r_z}, {czl, czr});
            chk("underrun", 32'(ur_h), 32'(und_exp));
            chk("underrun_z", 32'(ur_z), 32'(und_exp));
            chk("irq", 32'(irq_h), 32'(irq_exp));
            chk("irq_z", 32'(irq_z), 32'(irq_exp));
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #3;
        end
    endtask

    task automatic push(input logic [31:0] w);
        pend.push_back({1'b0, w});
    endtask

    task automatic do_reset();
        reset        = 1'b1;
        enable       = 1'b0;
        underrun_clr = 1'b0;
        pend.push_back({1'b1, 32'd0});
        step(3);
        reset = 1'b0;
        step(2);
    endtask

    task automatic wait_strobe(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (st_h) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_rd();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (rd_h) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) chk("rd_timeout", 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [DIV_W-1:0] rd;
        int               nw;
        logic [CNT_W-1:0] lvl;
        int               per;
        int               pops;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int   s1, sc, last, dmin, dmax, pops, run;

        tbl[0] = '{16'd9, 2, 10'd4, 10, 2};
        tbl[1] = '{16'd0, 3, 10'd0, 3, 3};
        tbl[2] = '{16'd1, 3, 10'd8, 3, 3};
        tbl[3] = '{16'd2, 1, 10'd2, 3, 1};
        tbl[4] = '{16'd5, 4, 10'd3, 6, 4};

        reset        = 1'b1;
        enable       = 1'b0;
        rate_div     = '0;
        irq_level    = '0;
        underrun_clr = 1'b0;
        step(3);
        chk("reset_irq", 32'(irq_h), 32'd0);
        chk("reset_samples", {l_h, r_h}, 32'd0);

        // basic playback, then underrun hold / zero and clear priority
        do_reset();
        rate_div = 16'd9;
        push(32'h1234_ABCD);
        push(32'h5678_0001);
        step(2);
        enable = 1'b1;
        wait_strobe("s1");
        chk("first_word", {l_h, r_h}, 32'h1234_ABCD);
        s1 = cyc;
        wait_strobe("s2");
        chk("second_word", {l_h, r_h}, 32'h5678_0001);
        chk("period_basic", 32'(cyc - s1), 32'd10);
        s1 = cyc;
        wait_strobe("s3");
        chk("period_underrun", 32'(cyc - s1), 32'd10);
        chk("hold_samples", {l_h, r_h}, 32'h5678_0001);
        chk("zero_samples", {l_z, r_z}, 32'h0000_0000);
        chk("underrun_set", 32'(ur_h), 32'd1);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("underrun_cleared", 32'(ur_h), 32'd0);
        step(6);
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        chk("set_beats_clear", 32'(ur_h), 32'd1);
        chk("set_beats_clear_z", 32'(ur_z), 32'd1);
        enable = 1'b0;
        step(6);

        // vector table: period clamp, one pop per tick, final underrun
        foreach (tbl[i]) begin
            do_reset();
            rate_div  = tbl[i].rd;
            irq_level = tbl[i].lvl;
            for (int j = 0; j < tbl[i].nw; j++) push($urandom);
            step(2);
            enable = 1'b1;
            last = -1; dmin = 1000000; dmax = 0; pops = 0; sc = 0;
            run = tbl[i].per * (tbl[i].nw + 3) + 6;
            for (int c = 0; c < run; c++) begin
                step();
                if (rd_h) pops++;
                if (st_h) begin
                    sc++;
                    if (last >= 0) begin
                        if (cyc - last < dmin) dmin = cyc - last;
                        if (cyc - last > dmax) dmax = cyc - last;
                    end
                    last = cyc;
                end
            end
            chk($sformatf("vec%0d_pmin", i), 32'(dmin), 32'(tbl[i].per));
            chk($sformatf("vec%0d_pmax", i), 32'(dmax), 32'(tbl[i].per));
            chk($sformatf("vec%0d_pops", i), 32'(pops), 32'(tbl[i].pops));
            chk($sformatf("vec%0d_ur", i), 32'(ur_h), 32'd1);
            enable = 1'b0;
            step(6);
        end

        // low-water interrupt edges
        do_reset();
        rate_div  = 16'd2;
        irq_level = 10'd4;
        for (int j = 0; j < 5; j++) push($urandom);
        step(2);
        enable = 1'b1;
        for (int c = 0; c < 100; c++) begin
            step();
            if (fifo_count == 10'd3) break;
        end
        chk("irq_cnt3", 32'(fifo_count), 32'd3);
        chk("irq_before", 32'(irq_h), 32'd0);
        step();
        chk("irq_low", 32'(irq_h), 32'd1);
        enable = 1'b0;
        step();
        chk("irq_disabled", 32'(irq_h), 32'd0);
        rate_div = 16'd200;
        step(8);
        enable = 1'b1;
        step();
        chk("irq_reenabled", 32'(irq_h), 32'd1);
        for (int c = 0; c < 10; c++) begin
            if (fifo_count >= 10'd4) break;
            push($urandom);
            step();
        end
        chk("irq_cnt4", 32'(fifo_count), 32'd4);
        chk("irq_still", 32'(irq_h), 32'd1);
        step();
        chk("irq_refilled", 32'(irq_h), 32'd0);
        enable = 1'b0;
        step(4);

        // async reset in the middle of a fetch
        do_reset();
        rate_div  = 16'd4;
        irq_level = 10'd10;
        push(32'hCAFE_F00D);
        step(2);
        enable = 1'b1;
        wait_strobe("r1");
        chk("rst_pre_word", {l_h, r_h}, 32'hCAFE_F00D);
        wait_strobe("r2");
        chk("rst_pre_ur", 32'(ur_h), 32'd1);
        push(32'h0BAD_0BAD);
        wait_rd();
        reset  = 1'b1;
        enable = 1'b0;
        pend.push_back({1'b1, 32'd0});
        #1;
        chk("rst_now_samples", {l_h, r_h}, 32'd0);
        chk("rst_now_flags", {28'd0, rd_h, st_h, ur_h, irq_h}, 32'd0);
        step(2);
        reset = 1'b0;
        step(2);
        push(32'h7777_8888);
        step(2);
        enable = 1'b1;
        wait_strobe("r3");
        chk("restart_word", {l_h, r_h}, 32'h7777_8888);
        enable = 1'b0;
        step(6);

        // randomized soak against the predictor
        do_reset();
        rate_div  = 16'($urandom_range(0, 6));
        irq_level = 10'($urandom_range(0, 8));
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0 && fq.size() < 900) push($urandom);
            if ($urandom_range(0, 49) == 0) rate_div = 16'($urandom_range(0, 6));
            if ($urandom_range(0, 59) == 0) irq_level = 10'($urandom_range(0, 8));
            if ($urandom_range(0, 99) == 0) enable = ~enable;
            else if (c < 10) enable = 1'b1;
            underrun_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        enable       = 1'b0;
        underrun_clr = 1'b0;
        step(6);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
